rf_seq_ctrl: RTL and testbench
==============================

// Module: rf_seq_ctrl
// PURPOSE
//  Sequencer for the 8-lane operand register file (x rows + w rows).
//  - Phase 1 (LOAD): accepts NUM_ROWS packed rows over a valid/ready stream and writes each into the RF at idx 0..rows-1.
//  - Phase 2 (STREAM): replays idx 0..rows-1 with write low, presenting operands to the MAC array under a valid/ready handshake.
//  - Sits between the input DMA/stream and the RF + multiplier array.
// PARAMETERS
//  DEPTH   8  RF rows per lane; max rows per job
//  IDX_W   3  RF index width, clog2(DEPTH)
//  LANES   8  RF data lanes (lanes 0-3 = x, lanes 4-7 = w)
//  DATA_W  8  bits per lane
// PORTS
//  clk         in   1              clock, rising edge
//  rst_n       in   1              asynchronous active-low reset
//  start       in   1              job start pulse; sampled only in IDLE
//  abort       in   1              synchronous abort, any state
//  num_rows    in   IDX_W+1        rows in job, latched on accepted start
//  in_valid    in   1              input row valid
//  in_ready    out  1              controller can accept a row
//  in_data     in   LANES*DATA_W   packed row; lane k = in_data[k*DATA_W +: DATA_W]
//  rf_enable   out  1              RF enable
//  rf_write    out  1              RF write strobe
//  rf_idx      out  IDX_W          RF row index
//  rf_data     out  LANES*DATA_W   RF write data, lane k -> data_in_k
//  mac_valid   out  1              RF outputs valid for MAC array
//  mac_ready   in   1              MAC array consumes current row
//  mac_last    out  1              current streamed row is the final row
//  busy        out  1              state != IDLE
//  done        out  1              one-cycle pulse at job completion
// BEHAVIOUR
//  Reset (rst_n low, async):
//   - state=IDLE, cnt=0, rows_q=0.
//   - All outputs 0.
//  FSM states: IDLE -> LOAD -> STREAM -> DONE -> IDLE.
//  IDLE:
//   - in_ready=0, rf_enable=0, mac_valid=0.
//   - On start: rows_q = min(num_rows, DEPTH), cnt=0.
//   - Next state is LOAD, or DONE when num_rows==0.
//  LOAD:
//   - in_ready=1.
//   - On accept (in_valid & in_ready), in the same cycle:
//     - rf_enable=1, rf_write=1, rf_idx=cnt, rf_data=in_data (combinational).
//     - cnt increments.
//   - On accept with cnt==rows_q-1: cnt<=0, next state STREAM.
//   - Without in_valid: rf_write=0, rf_enable=0, cnt holds.
//  STREAM:
//   - rf_enable=1, rf_write=0, rf_idx=cnt, mac_valid=1, in_ready=0.
//   - mac_last = (cnt==rows_q-1).
//   - On mac_ready: cnt increments.
//   - On mac_ready & mac_last: next state DONE.
//   - mac_ready low: rf_idx and mac_valid hold stable (no skip, no repeat).
//  DONE:
//   - done=1 for exactly one cycle; all other outputs 0; next state IDLE.
//  Latency:
//   - Zero-cycle write: row accepted at edge n is stored at edge n.
//   - Index 0 is presented the cycle after the final load accept.
//   - Minimum job length = 2*rows + 2 cycles (start cycle + DONE cycle).
//  Boundaries:
//   - start outside IDLE is ignored; num_rows is only sampled with an accepted start.
//   - num_rows > DEPTH is clamped to DEPTH; rf_idx never exceeds DEPTH-1 and never wraps.
//   - abort has priority over all transitions:
//     - next state IDLE, cnt=0, no done pulse.
//     - No RF write occurs in the abort cycle (rf_write forced 0).
//   - start and abort in the same cycle in IDLE: abort wins, stays IDLE.
//   - Async reset mid-job: immediate return to reset values; partially loaded RF contents are don't-care.
//   - busy=1 in LOAD, STREAM and DONE.
// TESTING
//  1. Reset release, no stimulus -> all outputs 0, state IDLE for 20 cycles.
//  2. start, num_rows=4, rows A0..A3 back-to-back, mac_ready=1:
//     - rf_write high 4 cycles with idx 0,1,2,3.
//     - mac_valid 4 cycles with idx 0..3; mac_last on idx 3.
//     - done pulse on cycle 10.
//  3. num_rows=8, in_valid toggling 1/0 and mac_ready low 2 cycles on idx 5:
//     - 8 writes, idx 0..7.
//     - rf_idx holds 5 for 3 cycles.
//     - Exactly 8 mac handshakes.
//  4. abort asserted after 2 load accepts:
//     - No write in the abort cycle; next cycle IDLE, busy=0, no done.
//     - A new start works normally.
//  5. num_rows=0 -> done the cycle after start, no rf_enable.
//     num_rows=12 -> clamped to 8 rows.
//  6. rst_n low during STREAM at idx 3 -> outputs 0 asynchronously; restart completes cleanly.

Source files
------------

// File: rtl/rf_seq_ctrl_if.sv
// Control, input-stream, RF and MAC signals of the operand sequencer.
// master = job/stream/MAC side, slave = the sequencer itself.
interface rf_seq_ctrl_if #(
  parameter int IDX_W  = 3,
  parameter int LANES  = 8,
  parameter int DATA_W = 8
);
  logic                      start;
  logic                      abort;
  logic [IDX_W:0]            num_rows;
  logic                      in_valid;
  logic                      in_ready;
  logic [LANES*DATA_W-1:0]   in_data;
  logic                      rf_enable;
  logic                      rf_write;
  logic [IDX_W-1:0]          rf_idx;
  logic [LANES*DATA_W-1:0]   rf_data;
  logic                      mac_valid;
  logic                      mac_ready;
  logic                      mac_last;
  logic                      busy;
  logic                      done;

  modport master (
    output start, abort, num_rows, in_valid, in_data, mac_ready,
    input  in_ready, rf_enable, rf_write, rf_idx, rf_data,
           mac_valid, mac_last, busy, done
  );

  modport slave (
    input  start, abort, num_rows, in_valid, in_data, mac_ready,
    output in_ready, rf_enable, rf_write, rf_idx, rf_data,
           mac_valid, mac_last, busy, done
  );
endinterface

// File: rtl/rf_seq_ctrl.sv
// Operand RF sequencer: loads rows from the input stream (written in the accept cycle),
// then replays them to the MAC array; in_ready/mac_valid stall cleanly under backpressure.
module rf_seq_ctrl #(
  parameter int DEPTH = 8,
  parameter int IDX_W = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  rf_seq_ctrl_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STREAM, S_DONE} state_t;

  localparam logic [IDX_W:0]   DEPTH_C = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W:0]   ONE_W   = (IDX_W+1)'(1);
  localparam logic [IDX_W-1:0] ONE_I   = IDX_W'(1);

  state_t           state;
  logic [IDX_W-1:0] cnt;
  logic [IDX_W-1:0] cnt_inc;
  logic [IDX_W:0]   rows_q;
  logic [IDX_W:0]   last_idx;
  logic [IDX_W:0]   clamp_rows;
  logic             in_ready_q;
  logic             mac_valid_q;
  logic             mac_last_q;
  logic             busy_q;
  logic             done_q;
  logic             rf_write_c;

  assign cnt_inc    = cnt + ONE_I;
  assign last_idx   = rows_q - ONE_W;
  assign clamp_rows = (bus.num_rows > DEPTH_C) ? DEPTH_C : bus.num_rows;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      rows_q      <= '0;
      in_ready_q  <= 1'b0;
      mac_valid_q <= 1'b0;
      mac_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else if (bus.abort) begin
      state       <= S_IDLE;
      cnt         <= '0;
      in_ready_q  <= 1'b0;
      mac_valid_q <= 1'b0;
      mac_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            rows_q <= clamp_rows;
            cnt    <= '0;
            busy_q <= 1'b1;
            if (bus.num_rows == '0) begin
              state  <= S_DONE;
              done_q <= 1'b1;
            end else begin
              state      <= S_LOAD;
              in_ready_q <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (bus.in_valid) begin
            if ({1'b0, cnt} == last_idx) begin
              cnt         <= '0;
              state       <= S_STREAM;
              in_ready_q  <= 1'b0;
              mac_valid_q <= 1'b1;
              mac_last_q  <= (last_idx == '0);
            end else begin
              cnt <= cnt_inc;
            end
          end
        end
        S_STREAM: begin
          // Index only moves on a handshake, so a stalled row is neither skipped nor repeated.
          if (bus.mac_ready) begin
            if (mac_last_q) begin
              cnt         <= '0;
              state       <= S_DONE;
              mac_valid_q <= 1'b0;
              mac_last_q  <= 1'b0;
              done_q      <= 1'b1;
            end else begin
              cnt        <= cnt_inc;
              mac_last_q <= ({1'b0, cnt_inc} == last_idx);
            end
          end
        end
        default: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  // Write path is combinational so a row is stored on the same edge it is accepted.
  assign rf_write_c    = in_ready_q & bus.in_valid & ~bus.abort;

  assign bus.in_ready  = in_ready_q;
  assign bus.rf_write  = rf_write_c;
  assign bus.rf_enable = rf_write_c | mac_valid_q;
  assign bus.rf_idx    = cnt;
  assign bus.rf_data   = rf_write_c ? bus.in_data : '0;
  assign bus.mac_valid = mac_valid_q;
  assign bus.mac_last  = mac_last_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_rf_seq_ctrl.sv
// Directed bench for rf_seq_ctrl: inputs change 1ns after posedge, outputs checked at negedge.
module tb_rf_seq_ctrl;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  rf_seq_ctrl_if #(.IDX_W(3), .LANES(8), .DATA_W(8)) bus ();

  rf_seq_ctrl #(.DEPTH(8), .IDX_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] row_pat(input int k);
    logic [63:0] base;
    base = 64'h0123_4567_89AB_CD00;
    return base | 64'(k);
  endfunction

  // Start a job, load back-to-back, stream with mac_ready held high.
  task automatic run_job(input int nreq, input int nexp, input string tag);
    logic [3:0] nr;
    nr = nreq[3:0];
    bus.num_rows = nr;
    bus.start    = 1'b1;
    @(negedge clk);
    chk({tag, "_start_busy"}, bus.busy, 1'b0);
    tick();
    bus.start = 1'b0;
    for (int k = 0; k < nexp; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = row_pat(k);
      @(negedge clk);
      chk({tag, "_ld_wr"},   bus.rf_write, 1'b1);
      chk({tag, "_ld_idx"},  bus.rf_idx, k);
      chk({tag, "_ld_data"}, bus.rf_data, row_pat(k));
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.mac_ready = 1'b1;
    for (int k = 0; k < nexp; k++) begin
      @(negedge clk);
      chk({tag, "_st_vld"},  bus.mac_valid, 1'b1);
      chk({tag, "_st_idx"},  bus.rf_idx, k);
      chk({tag, "_st_wr"},   bus.rf_write, 1'b0);
      chk({tag, "_st_last"}, bus.mac_last, (k == nexp - 1));
      tick();
    end
    bus.mac_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_done"},     bus.done, 1'b1);
    chk({tag, "_done_en"},  bus.rf_enable, 1'b0);
    chk({tag, "_done_bsy"}, bus.busy, 1'b1);
    tick();
    @(negedge clk);
    chk({tag, "_idle_done"}, bus.done, 1'b0);
    chk({tag, "_idle_bsy"},  bus.busy, 1'b0);
    tick();
  endtask

  initial begin
    int exp_idx;
    int hs;
    int stall;
    int hold5;

    vectors       = 0;
    miscompares   = 0;
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    bus.num_rows  = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.mac_ready = 1'b0;

    // 1: reset release, idle for 20 cycles
    #23 rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("t1_idle_outs",
          {bus.in_ready, bus.rf_enable, bus.rf_write, bus.rf_idx, bus.mac_valid,
           bus.mac_last, bus.busy, bus.done}, '0);
      chk("t1_idle_data", bus.rf_data, '0);
    end
    tick();

    // 2: four rows, back-to-back, done on cycle 10
    run_job(4, 4, "t2");

    // 3: eight rows, in_valid toggling, MAC stall on idx 5, late start ignored
    bus.num_rows = 4'd8;
    bus.start    = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = row_pat(k + 16);
      if (k == 3) begin
        bus.start    = 1'b1;
        bus.num_rows = 4'd2;
      end
      @(negedge clk);
      chk("t3_ld_wr",   bus.rf_write, 1'b1);
      chk("t3_ld_idx",  bus.rf_idx, k);
      chk("t3_ld_data", bus.rf_data, row_pat(k + 16));
      tick();
      bus.start = 1'b0;
      if (k < 7) begin
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("t3_gap_wr",  bus.rf_write, 1'b0);
        chk("t3_gap_en",  bus.rf_enable, 1'b0);
        chk("t3_gap_idx", bus.rf_idx, k + 1);
        tick();
      end
    end
    bus.in_valid = 1'b0;
    exp_idx = 0;
    hs      = 0;
    stall   = 0;
    hold5   = 0;
    for (int c = 0; c < 20 && hs < 8; c++) begin
      if (exp_idx == 5 && stall < 2) begin
        bus.mac_ready = 1'b0;
        stall++;
      end else begin
        bus.mac_ready = 1'b1;
      end
      @(negedge clk);
      chk("t3_st_vld", bus.mac_valid, 1'b1);
      chk("t3_st_idx", bus.rf_idx, exp_idx);
      if (bus.rf_idx == 3'd5) hold5++;
      if (bus.mac_ready && bus.mac_valid) begin
        hs++;
        exp_idx++;
      end
      tick();
    end
    bus.mac_ready = 1'b0;
    chk("t3_handshakes", hs, 8);
    chk("t3_hold5", hold5, 3);
    @(negedge clk);
    chk("t3_done", bus.done, 1'b1);
    tick();

    // 4: abort after two accepts; start+abort in IDLE; restart
    bus.num_rows = 4'd4;
    bus.start    = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = row_pat(k + 32);
      @(negedge clk);
      chk("t4_ld_wr", bus.rf_write, 1'b1);
      tick();
    end
    bus.abort = 1'b1;
    @(negedge clk);
    chk("t4_abort_wr", bus.rf_write, 1'b0);
    chk("t4_abort_en", bus.rf_enable, 1'b0);
    tick();
    bus.abort    = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("t4_post_busy",  bus.busy, 1'b0);
    chk("t4_post_rdy",   bus.in_ready, 1'b0);
    chk("t4_post_done",  bus.done, 1'b0);
    tick();
    @(negedge clk);
    chk("t4_post_done2", bus.done, 1'b0);
    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    @(negedge clk);
    chk("t4_sa_busy", bus.busy, 1'b0);
    chk("t4_sa_rdy",  bus.in_ready, 1'b0);
    tick();
    run_job(5, 5, "t4r");

    // 5: zero rows, then clamp of 12 to 8
    bus.num_rows = 4'd0;
    bus.start    = 1'b1;
    tick();
    bus.start = 1'b0;
    @(negedge clk);
    chk("t5_zero_done", bus.done, 1'b1);
    chk("t5_zero_en",   bus.rf_enable, 1'b0);
    chk("t5_zero_rdy",  bus.in_ready, 1'b0);
    chk("t5_zero_busy", bus.busy, 1'b1);
    tick();
    @(negedge clk);
    chk("t5_zero_idle", bus.busy, 1'b0);
    tick();
    run_job(12, 8, "t5c");

    // 6: async reset while streaming idx 3, then clean restart
    bus.num_rows = 4'd8;
    bus.start    = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = row_pat(k + 48);
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.mac_ready = 1'b1;
    tick();
    tick();
    tick();
    bus.mac_ready = 1'b0;
    @(negedge clk);
    chk("t6_pre_idx", bus.rf_idx, 3);
    chk("t6_pre_vld", bus.mac_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_vld",  bus.mac_valid, 1'b0);
    chk("t6_rst_en",   bus.rf_enable, 1'b0);
    chk("t6_rst_busy", bus.busy, 1'b0);
    chk("t6_rst_idx",  bus.rf_idx, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run_job(3, 3, "t6r");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
